// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//   Sequencer for the 2-digit countdown display path. Holds the BCD count, runs
//   the count-step prescaler and decrements the count while running. The digit
//   outputs feed the 7-segment decoder/scanner; blank flashes the display while
//   the count sits at 00.
//
//   Buttons are already-debounced single-cycle pulses in the clk domain.
//   Same-cycle command priority is clear > load > start_stop. Whenever a higher
//   command is present the lower ones are dropped, even if the higher one is
//   itself ignored (load in RUN, load with a non-BCD digit).
//
// Parameters
//   TICK_DIV     clk cycles per count step (>= 2)
//   PRESET_TENS  tens digit loaded at reset / clear / acknowledge (BCD)
//   PRESET_ONES  ones digit loaded at reset / clear / acknowledge (BCD)
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   start_stop   pulse: start / pause / resume / acknowledge done
//   load         pulse: load load_tens:load_ones as the new count
//   load_tens    BCD tens digit for load
//   load_ones    BCD ones digit for load
//   clear        pulse: return to preset, IDLE
//   bcd_tens     current count, tens digit (registered)
//   bcd_ones     current count, ones digit (registered)
//   running      1 in RUN
//   paused       1 in PAUSE
//   done         1 in DONE
//   blank        1 = display off (blink phase, DONE only)
//   tick         1-cycle pulse on every decrement, including the one that
//                reaches 00 (so it coincides with the first cycle of done)
// -----------------------------------------------------------------------------
module countdown_ctrl #(
  parameter int unsigned TICK_DIV    = 1_000_000,
  parameter logic [3:0]  PRESET_TENS = 4'd6,
  parameter logic [3:0]  PRESET_ONES = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       clear,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       blank,
  output logic       tick
);

  localparam int unsigned    PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TERM = PW'(TICK_DIV - 1);

  // One-hot encoding so the status outputs are plain register bits.
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_RUN   = 4'b0010;
  localparam logic [3:0] ST_PAUSE = 4'b0100;
  localparam logic [3:0] ST_DONE  = 4'b1000;

  // BCD decrement of a two-digit count; 00 stays 00 (no wrap to 99).
  function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] r;
    if (o != 4'd0)      r = {t, o - 4'd1};
    else if (t != 4'd0) r = {t - 4'd1, 4'd9};
    else                r = 8'h00;
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [3:0] t, input logic [3:0] o);
    return (t <= 4'd9) && (o <= 4'd9);
  endfunction

  logic [3:0]    state, state_nxt;
  logic [3:0]    tens_nxt, ones_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          blank_nxt, tick_nxt;

  logic          presc_term;
  logic          count_zero;
  logic          load_ok;
  logic          cmd_ss;
  logic [7:0]    dec_val;

  assign presc_term = (presc == TERM);
  assign count_zero = ({bcd_tens, bcd_ones} == 8'h00);
  assign dec_val    = bcd_dec(bcd_tens, bcd_ones);

  // A present load masks start_stop whether or not the load is accepted.
  assign load_ok = load && !clear && (state != ST_RUN) && bcd_ok(load_tens, load_ones);
  assign cmd_ss  = start_stop && !load && !clear;

  always_comb begin
    state_nxt = state;
    tens_nxt  = bcd_tens;
    ones_nxt  = bcd_ones;
    presc_nxt = presc;
    blank_nxt = blank;
    tick_nxt  = 1'b0;

    if (clear) begin
      state_nxt = ST_IDLE;
      tens_nxt  = PRESET_TENS;
      ones_nxt  = PRESET_ONES;
      presc_nxt = '0;
      blank_nxt = 1'b0;
    end else if (load_ok) begin
      state_nxt = ST_IDLE;
      tens_nxt  = load_tens;
      ones_nxt  = load_ones;
      presc_nxt = '0;
      blank_nxt = 1'b0;
    end else if (cmd_ss) begin
      // A start_stop edge never advances the prescaler: a pause taken on the
      // terminal cycle therefore resumes with the step still pending.
      unique case (state)
        ST_IDLE: begin
          if (!count_zero) begin
            state_nxt = ST_RUN;
            presc_nxt = '0;
          end
        end
        ST_RUN:   state_nxt = ST_PAUSE;
        ST_PAUSE: state_nxt = ST_RUN;
        ST_DONE: begin
          state_nxt = ST_IDLE;
          tens_nxt  = PRESET_TENS;
          ones_nxt  = PRESET_ONES;
          presc_nxt = '0;
          blank_nxt = 1'b0;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else begin
      // No effective command (this includes an ignored load).
      unique case (state)
        ST_IDLE: presc_nxt = '0;
        ST_RUN: begin
          if (presc_term) begin
            presc_nxt = '0;
            if (!count_zero) begin
              tens_nxt = dec_val[7:4];
              ones_nxt = dec_val[3:0];
              tick_nxt = 1'b1;
            end
            if (dec_val == 8'h00) state_nxt = ST_DONE;
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
        ST_PAUSE: presc_nxt = presc;
        ST_DONE: begin
          if (presc_term) begin
            presc_nxt = '0;
            blank_nxt = !blank;
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State / count register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bcd_tens <= PRESET_TENS;
      bcd_ones <= PRESET_ONES;
      presc    <= '0;
      blank    <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bcd_tens <= tens_nxt;
      bcd_ones <= ones_nxt;
      presc    <= presc_nxt;
      blank    <= blank_nxt;
      tick     <= tick_nxt;
    end
  end

  assign running = state[1];
  assign paused  = state[2];
  assign done    = state[3];

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

  localparam int TD  = 4;
  localparam int PRE = 60;

  logic       clk, rst;
  logic       start_stop, load, clear;
  logic [3:0] load_tens, load_ones;
  logic [3:0] bcd_tens, bcd_ones;
  logic       running, paused, done, blank, tick;

  int checks   = 0;
  int failures = 0;

  countdown_ctrl #(.TICK_DIV(TD), .PRESET_TENS(4'd6), .PRESET_ONES(4'd0)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .load(load),
    .load_tens(load_tens), .load_ones(load_ones), .clear(clear),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .running(running),
    .paused(paused), .done(done), .blank(blank), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (integer count, named modes) ----------
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int mst, cnt, ph;
  bit mblank, mtick;

  task automatic model_reset();
    mst = M_IDLE; cnt = PRE; ph = 0; mblank = 0; mtick = 0;
  endtask

  task automatic model_idle_with(input int value);
    mst = M_IDLE; cnt = value; ph = 0; mblank = 0;
  endtask

  task automatic model_advance();
    case (mst)
      M_IDLE: ph = 0;
      M_RUN: begin
        if (ph == TD - 1) begin
          ph = 0; cnt = cnt - 1; mtick = 1;
          if (cnt == 0) mst = M_DONE;
        end else ph++;
      end
      M_DONE: begin
        if (ph == TD - 1) begin ph = 0; mblank = !mblank; end
        else ph++;
      end
      default: ;
    endcase
  endtask

  task automatic model_step(input bit ss, input bit ld, input int lt, input int lo, input bit clr);
    mtick = 0;
    if (clr) model_idle_with(PRE);
    else if (ld) begin
      if (mst != M_RUN && lt <= 9 && lo <= 9) model_idle_with(lt * 10 + lo);
      else model_advance();
    end else if (ss) begin
      case (mst)
        M_IDLE:  if (cnt != 0) begin mst = M_RUN; ph = 0; end
        M_RUN:   mst = M_PAUSE;
        M_PAUSE: mst = M_RUN;
        M_DONE:  model_idle_with(PRE);
        default: ;
      endcase
    end else model_advance();
  endtask

  // ---------------- checking helpers ---------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_tens"},    int'(bcd_tens), cnt / 10);
    chk({tag, "_ones"},    int'(bcd_ones), cnt % 10);
    chk({tag, "_running"}, int'(running),  int'(mst == M_RUN));
    chk({tag, "_paused"},  int'(paused),   int'(mst == M_PAUSE));
    chk({tag, "_done"},    int'(done),     int'(mst == M_DONE));
    chk({tag, "_blank"},   int'(blank),    int'(mblank));
    chk({tag, "_tick"},    int'(tick),     int'(mtick));
  endtask

  task automatic idle_inputs();
    start_stop = 0; load = 0; clear = 0; load_tens = 0; load_ones = 0;
  endtask

  // One clock: inputs are already set; the model sees the same inputs the DUT
  // samples, outputs are observed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step(start_stop, load, int'(load_tens), int'(load_ones), clear);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic       ss, ld, clr;
    logic [3:0] lt, lo;
    logic [3:0] et, eo;
    logic       er, ep, ed, eb, etk;
  } vec_t;

  function automatic vec_t v(input logic ss, input logic ld, input logic clr,
                             input logic [3:0] lt, input logic [3:0] lo,
                             input logic [3:0] et, input logic [3:0] eo,
                             input logic er, input logic ep, input logic ed,
                             input logic eb, input logic etk);
    vec_t r;
    r.ss = ss; r.ld = ld; r.clr = clr; r.lt = lt; r.lo = lo;
    r.et = et; r.eo = eo; r.er = er; r.ep = ep; r.ed = ed; r.eb = eb; r.etk = etk;
    return r;
  endfunction

  vec_t tbl[28];
  int   nticks, k;

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();

    //           ss ld clr lt    lo     tens ones run pau don blk tck
    tbl[0]  = v(1, 0, 0, 4'd0, 4'd0,  6, 0,  1, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 0, 4'd0, 4'd0,  6, 0,  1, 0, 0, 0, 0);
    tbl[2]  = v(0, 0, 0, 4'd0, 4'd0,  6, 0,  1, 0, 0, 0, 0);
    tbl[3]  = v(0, 0, 0, 4'd0, 4'd0,  6, 0,  1, 0, 0, 0, 0);
    tbl[4]  = v(0, 0, 0, 4'd0, 4'd0,  5, 9,  1, 0, 0, 0, 1);
    tbl[5]  = v(0, 0, 0, 4'd0, 4'd0,  5, 9,  1, 0, 0, 0, 0);
    tbl[6]  = v(1, 0, 0, 4'd0, 4'd0,  5, 9,  0, 1, 0, 0, 0);
    tbl[7]  = v(0, 1, 0, 4'hA, 4'd3,  5, 9,  0, 1, 0, 0, 0);
    tbl[8]  = v(1, 0, 0, 4'd0, 4'd0,  5, 9,  1, 0, 0, 0, 0);
    tbl[9]  = v(0, 0, 0, 4'd0, 4'd0,  5, 9,  1, 0, 0, 0, 0);
    tbl[10] = v(0, 0, 0, 4'd0, 4'd0,  5, 9,  1, 0, 0, 0, 0);
    tbl[11] = v(0, 0, 0, 4'd0, 4'd0,  5, 8,  1, 0, 0, 0, 1);
    tbl[12] = v(0, 1, 0, 4'd1, 4'd0,  5, 8,  1, 0, 0, 0, 0);
    tbl[13] = v(1, 1, 1, 4'd1, 4'd0,  6, 0,  0, 0, 0, 0, 0);
    tbl[14] = v(0, 1, 0, 4'd0, 4'd1,  0, 1,  0, 0, 0, 0, 0);
    tbl[15] = v(1, 0, 0, 4'd0, 4'd0,  0, 1,  1, 0, 0, 0, 0);
    tbl[16] = v(0, 0, 0, 4'd0, 4'd0,  0, 1,  1, 0, 0, 0, 0);
    tbl[17] = v(0, 0, 0, 4'd0, 4'd0,  0, 1,  1, 0, 0, 0, 0);
    tbl[18] = v(0, 0, 0, 4'd0, 4'd0,  0, 1,  1, 0, 0, 0, 0);
    tbl[19] = v(0, 0, 0, 4'd0, 4'd0,  0, 0,  0, 0, 1, 0, 1);
    tbl[20] = v(0, 0, 0, 4'd0, 4'd0,  0, 0,  0, 0, 1, 0, 0);
    tbl[21] = v(0, 0, 0, 4'd0, 4'd0,  0, 0,  0, 0, 1, 0, 0);
    tbl[22] = v(0, 0, 0, 4'd0, 4'd0,  0, 0,  0, 0, 1, 0, 0);
    tbl[23] = v(0, 0, 0, 4'd0, 4'd0,  0, 0,  0, 0, 1, 1, 0);
    tbl[24] = v(1, 0, 0, 4'd0, 4'd0,  6, 0,  0, 0, 0, 0, 0);
    tbl[25] = v(0, 1, 0, 4'd0, 4'd0,  0, 0,  0, 0, 0, 0, 0);
    tbl[26] = v(1, 0, 0, 4'd0, 4'd0,  0, 0,  0, 0, 0, 0, 0);
    tbl[27] = v(0, 1, 0, 4'd5, 4'd9,  5, 9,  0, 0, 0, 0, 0);

    // Reset values while rst is held.
    #2;
    chk("rst_tens", int'(bcd_tens), 6);
    chk("rst_ones", int'(bcd_ones), 0);
    chk("rst_status", int'({running, paused, done, blank, tick}), 0);
    @(posedge clk); #1;
    rst = 0;

    // ---- table phase ----
    for (int i = 0; i < 28; i++) begin
      start_stop = tbl[i].ss; load = tbl[i].ld; clear = tbl[i].clr;
      load_tens = tbl[i].lt; load_ones = tbl[i].lo;
      cyc();
      chk($sformatf("vec%0d_tens", i),    int'(bcd_tens), int'(tbl[i].et));
      chk($sformatf("vec%0d_ones", i),    int'(bcd_ones), int'(tbl[i].eo));
      chk($sformatf("vec%0d_running", i), int'(running),  int'(tbl[i].er));
      chk($sformatf("vec%0d_paused", i),  int'(paused),   int'(tbl[i].ep));
      chk($sformatf("vec%0d_done", i),    int'(done),     int'(tbl[i].ed));
      chk($sformatf("vec%0d_blank", i),   int'(blank),    int'(tbl[i].eb));
      chk($sformatf("vec%0d_tick", i),    int'(tick),     int'(tbl[i].etk));
    end

    // ---- randomized phase against the reference model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start_stop = ($urandom_range(0, 7) == 0);
      load       = ($urandom_range(0, 24) == 0);
      clear      = ($urandom_range(0, 59) == 0);
      load_tens  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
      load_ones  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      cyc();
      chk_model($sformatf("rnd%0d", i));
    end

    // ---- full 60-step run from preset to DONE ----
    do_reset();
    start_stop = 1;
    cyc();
    nticks = 0;
    k = 0;
    while (mst != M_DONE && k < 400) begin
      cyc();
      chk_model("run60");
      if (tick) nticks++;
      k++;
    end
    chk("run60_ticks", nticks, 60);
    chk("run60_cycles", k, 60 * TD);
    chk("run60_done", int'(done), 1);
    chk("run60_running", int'(running), 0);
    // blank toggles every TD clocks while DONE
    for (int i = 0; i < 3 * TD; i++) begin
      cyc();
      chk_model("blink");
    end

    // ---- pause 2 clocks into a period, frozen, resume latency ----
    do_reset();
    start_stop = 1; cyc();
    cyc(); cyc();
    start_stop = 1; cyc();
    chk("pause_paused", int'(paused), 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("pause_frozen", int'({bcd_tens, bcd_ones}), 8'h60);
      chk("pause_notick", int'(tick), 0);
    end
    start_stop = 1; cyc();
    chk("resume_running", int'(running), 1);
    k = 0;
    do begin
      cyc();
      k++;
    end while (!tick && k < 10);
    chk("resume_latency", k, 2);
    chk("resume_count", int'({bcd_tens, bcd_ones}), 8'h59);

    // ---- asynchronous reset between edges mid-RUN ----
    do_reset();
    start_stop = 1; cyc();
    for (int i = 0; i < 5; i++) cyc();
    #2;
    rst = 1;
    #1;
    chk("arst_tens", int'(bcd_tens), 6);
    chk("arst_ones", int'(bcd_ones), 0);
    chk("arst_status", int'({running, paused, done, blank, tick}), 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    cyc();
    chk_model("arst_rel");
    chk("arst_idle", int'({running, paused, done}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
